// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared encodings for the mul/div issue controller. Holds the unit
//            command encodings, the RV32M funct3 values, the controller state
//            type and a small two's-complement helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // Command encodings driven on md_op
  localparam logic [1:0] MD_OP_IDLE = 2'd0;
  localparam logic [1:0] MD_OP_MUL  = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;

  // RV32M funct3 values
  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_WB    = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  function automatic logic [31:0] negate32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sign_fix
// Purpose  : Combinational result correction for the FIX stage. The unit only
//            sees magnitudes, so signs are re-applied here and the word that
//            the instruction writes back is selected.
// Ports    : i_funct3  RV32M funct3 of the in-flight instruction
//            i_neg1    operand 1 was negated before issue
//            i_neg2    operand 2 was negated before issue
//            i_high    unit high word (product[63:32] / remainder)
//            i_low     unit low word  (product[31:0]  / quotient)
//            o_result  corrected write-back value
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_neg1,
  input  logic        i_neg2,
  input  logic [31:0] i_high,
  input  logic [31:0] i_low,
  output logic [31:0] o_result
);

  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  always_comb begin
    // Product sign is the xor of operand signs; the full 64 bits are negated
    // so the borrow from the low word propagates into the high word.
    w_prod = (i_neg1 ^ i_neg2) ? (~{i_high, i_low} + 64'd1) : {i_high, i_low};
    w_quot = (i_neg1 ^ i_neg2) ? negate32(i_low) : i_low;
    // Remainder takes the sign of the dividend.
    w_rem  = i_neg1 ? negate32(i_high) : i_high;

    case (i_funct3)
      FUNCT3_MUL:                             o_result = w_prod[31:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: o_result = w_prod[63:32];
      FUNCT3_DIV, FUNCT3_DIVU:                o_result = w_quot;
      default:                                o_result = w_rem;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl
// Purpose  : Requester side of the multi-cycle mul/div unit. Accepts one RV32M
//            instruction from EX, issues unsigned magnitudes to the unit and
//            holds the command until md_ready, re-applies signs, handles the
//            RISC-V divide corner cases without the unit, and returns a single
//            write-back beat. busy stalls the pipeline while not idle.
// Ports    : clk, rst                 clock, async active-high reset
//            req_valid/req_ready      EX handshake (ready only in IDLE)
//            req_funct3/rd/rs1/rs2    decoded instruction and operand values
//            flush                    squash the in-flight instruction
//            md_op, md_rs1/2(_signed) command and magnitudes to the unit
//            md_high/md_low/md_ready  unit result
//            md_stall                 unit busy (informational only)
//            wb_valid/wb_rd/wb_data   one-cycle write-back beat
//            busy                     controller not idle
//            timeout_err              sticky unit-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic [1:0]  md_op,
  output logic [31:0] md_rs1,
  output logic        md_rs1_signed,
  output logic [31:0] md_rs2,
  output logic        md_rs2_signed,
  input  logic [31:0] md_high,
  input  logic [31:0] md_low,
  input  logic        md_ready,
  input  logic        md_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout_err
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_funct3;
  logic [4:0]         r_rd;
  logic               r_neg1;
  logic               r_neg2;
  logic [31:0]        r_md_rs1;
  logic [31:0]        r_md_rs2;
  logic [31:0]        r_high;
  logic [31:0]        r_low;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout_err;
  logic [4:0]         r_wb_rd;
  logic [31:0]        r_wb_data;

  logic               w_accept;
  logic               w_capture;
  logic               w_wb_load;
  logic               w_timeout_hit;
  logic               w_neg1;
  logic               w_neg2;
  logic               w_corner;
  logic [31:0]        w_corner_data;
  logic [31:0]        w_fix_result;
  logic               w_unused_stall;

  // md_stall is informational; md_ready alone advances the controller.
  assign w_unused_stall = md_stall;

  // --------------------------------------------------------------------------
  // Accept-time decode
  // --------------------------------------------------------------------------
  always_comb begin
    // MUL is treated as signed x signed: its low word is identical to the
    // unsigned product, and sending magnitudes keeps the unit uniform.
    w_neg1 = req_rs1[31] & ((req_funct3 == FUNCT3_MUL)  | (req_funct3 == FUNCT3_MULH) |
                            (req_funct3 == FUNCT3_MULHSU) |
                            (req_funct3 == FUNCT3_DIV)  | (req_funct3 == FUNCT3_REM));
    w_neg2 = req_rs2[31] & ((req_funct3 == FUNCT3_MUL)  | (req_funct3 == FUNCT3_MULH) |
                            (req_funct3 == FUNCT3_DIV)  | (req_funct3 == FUNCT3_REM));

    // funct3[2] marks the divide group; funct3[1] separates REM* from DIV*.
    w_corner      = 1'b0;
    w_corner_data = 32'd0;
    if (req_funct3[2] && (req_rs2 == 32'd0)) begin
      w_corner      = 1'b1;
      w_corner_data = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (((req_funct3 == FUNCT3_DIV) || (req_funct3 == FUNCT3_REM)) &&
                 (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF)) begin
      w_corner      = 1'b1;
      w_corner_data = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_wb_load     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_corner ? ST_WB : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A result arriving with flush is already complete, so there is
        // nothing left to drain.
        if (flush) begin
          w_state_nxt = md_ready ? ST_GAP : ST_DRAIN;
        end else if (md_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FIX;
        end else if (r_cnt == c_TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_GAP;
        end
      end
      ST_DRAIN: begin
        if (md_ready) begin
          w_state_nxt = ST_GAP;
        end else if (r_cnt == c_TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_GAP;
        end
      end
      ST_FIX: begin
        w_wb_load   = ~flush;
        w_state_nxt = flush ? ST_GAP : ST_WB;
      end
      ST_WB:   w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  muldiv_sign_fix u_sign_fix (
    .i_funct3 (r_funct3),
    .i_neg1   (r_neg1),
    .i_neg2   (r_neg2),
    .i_high   (r_high),
    .i_low    (r_low),
    .o_result (w_fix_result)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_funct3      <= 3'd0;
      r_rd          <= 5'd0;
      r_neg1        <= 1'b0;
      r_neg2        <= 1'b0;
      r_md_rs1      <= 32'd0;
      r_md_rs2      <= 32'd0;
      r_high        <= 32'd0;
      r_low         <= 32'd0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_data     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_rd     <= req_rd;
        r_neg1   <= w_neg1;
        r_neg2   <= w_neg2;
        r_cnt    <= '0;
        if (w_corner) begin
          r_wb_rd   <= req_rd;
          r_wb_data <= w_corner_data;
        end else begin
          // 0x80000000 negates to itself, which is the correct magnitude.
          r_md_rs1 <= w_neg1 ? negate32(req_rs1) : req_rs1;
          r_md_rs2 <= w_neg2 ? negate32(req_rs2) : req_rs2;
        end
      end else if ((r_state == ST_ISSUE) && (w_state_nxt == ST_DRAIN)) begin
        r_cnt <= '0;
      end else if ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end

      if (w_capture) begin
        r_high <= md_high;
        r_low  <= md_low;
      end

      if (w_wb_load) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_fix_result;
      end

      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (derived from the async-reset state so rst clears them at once)
  // --------------------------------------------------------------------------
  always_comb begin
    md_op = MD_OP_IDLE;
    if ((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) begin
      md_op = r_funct3[2] ? MD_OP_DIV : MD_OP_MUL;
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign md_rs1        = r_md_rs1;
  assign md_rs2        = r_md_rs2;
  assign md_rs1_signed = 1'b0;
  assign md_rs2_signed = 1'b0;
  assign wb_valid      = (r_state == ST_WB) & ~flush;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue_ctrl
// Purpose  : Self-checking bench for muldiv_issue_ctrl. A behavioural mul/div
//            unit answers commands after a chosen latency; expected write-back
//            beats come from a signed/unsigned arithmetic reference model and
//            are queued at issue time, then popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        flush;
  logic [1:0]  md_op;
  logic [31:0] md_rs1;
  logic        md_rs1_signed;
  logic [31:0] md_rs2;
  logic        md_rs2_signed;
  logic [31:0] md_high;
  logic [31:0] md_low;
  logic        md_ready;
  logic        md_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        timeout_err;

  muldiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_rd        (req_rd),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .flush         (flush),
    .md_op         (md_op),
    .md_rs1        (md_rs1),
    .md_rs1_signed (md_rs1_signed),
    .md_rs2        (md_rs2),
    .md_rs2_signed (md_rs2_signed),
    .md_high       (md_high),
    .md_low        (md_low),
    .md_ready      (md_ready),
    .md_stall      (md_stall),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    int          t_acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  int   unit_lat      = 0;
  bit   unit_hang     = 1'b0;
  bit   watch_md_idle = 1'b0;
  int   last_wb       = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32M semantics in 64-bit signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
      3'd5: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end end
      3'd6: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
      default: begin if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end end
    endcase
    return r;
  endfunction

  function automatic bit is_corner(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 32'd0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] pool [6];
    pool = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Behavioural unit: answers with unsigned results after unit_lat cycles
  // and holds ready until the command drops back to idle.
  initial begin
    int ucnt;
    ucnt     = 0;
    md_ready = 1'b0;
    md_high  = 32'd0;
    md_low   = 32'd0;
    md_stall = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (md_op == 2'd0) begin
        ucnt     = 0;
        md_ready = 1'b0;
      end else if (!md_ready && !unit_hang) begin
        if (ucnt >= unit_lat) begin
          if (md_op == 2'd1) begin
            {md_high, md_low} = {32'd0, md_rs1} * {32'd0, md_rs2};
          end else begin
            md_low  = (md_rs2 != 0) ? md_rs1 / md_rs2 : 32'hFFFF_FFFF;
            md_high = (md_rs2 != 0) ? md_rs1 % md_rs2 : md_rs1;
          end
          md_ready = 1'b1;
        end else begin
          ucnt++;
        end
      end
      md_stall = (md_op != 2'd0) && !md_ready;
    end
  end

  // Monitor: pops the scoreboard on every write-back beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (watch_md_idle) check("corner_md_op_idle", md_op, 2'd0);
      if (cyc == last_wb + 1) begin
        check("wb_one_cycle", wb_valid, 1'b0);
        check("gap_md_op", md_op, 2'd0);
        check("gap_busy", busy, 1'b1);
      end
      if (cyc == last_wb + 2) check("ready_after_gap", req_ready, 1'b1);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got rd=%0d data=0x%0h expected no write-back (cycle %0d)",
                   wb_rd, wb_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_rd"}, wb_rd, e.rd);
          check({e.name, "_data"}, wb_data, e.data);
          check({e.name, "_latency"}, cyc - e.t_acc, e.lat);
        end
        last_wb = cyc;
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit expect_wb, input string name);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_req_ready"}, req_ready, 1'b1);
    unit_lat   = lat;
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rd     = rd;
    req_rs1    = a;
    req_rs2    = b;
    if (expect_wb) begin
      e.rd    = rd;
      e.data  = ref_result(f3, a, b);
      e.lat   = is_corner(f3, a, b) ? 1 : 3 + lat;
      e.t_acc = cyc;
      e.name  = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    req_rd    = 5'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    int d;
    logic [2:0] f3;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_rd     = 5'd0;
    req_rs1    = 32'd0;
    req_rs2    = 32'd0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_md_op", md_op, 2'd0);
    check("reset_md_rs1", md_rs1, 32'd0);
    check("reset_md_rs2", md_rs2, 32'd0);
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_wb_rd", wb_rd, 5'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_timeout", timeout_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);
    rst = 1'b0;

    // Directed multiply / divide
    issue(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFD, 2, 1'b1, "mul_7xm3");
    check("mul_md_op", md_op, 2'd1);
    check("mul_md_rs1", md_rs1, 32'd7);
    check("mul_md_rs2", md_rs2, 32'd3);
    check("mul_signed_flags", {md_rs1_signed, md_rs2_signed}, 2'b00);
    issue(3'd1, 5'd6, 32'h8000_0000, 32'h8000_0000, 1, 1'b1, "mulh_min");
    issue(3'd3, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1, "mulhu_max");
    issue(3'd4, 5'd8, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, "div_m7_2");
    check("div_md_op", md_op, 2'd2);
    check("div_md_rs1", md_rs1, 32'd7);
    check("div_md_rs2", md_rs2, 32'd2);
    issue(3'd6, 5'd9, 32'hFFFF_FFF9, 32'd2, 4, 1'b1, "rem_m7_2");
    issue(3'd7, 5'd10, 32'd7, 32'd2, 1, 1'b1, "remu_7_2");
    wait_idle("directed");

    // Corner cases bypass the unit
    watch_md_idle = 1'b1;
    issue(3'd4, 5'd12, 32'd5, 32'd0, 0, 1'b1, "div_by0");
    issue(3'd6, 5'd13, 32'd5, 32'd0, 0, 1'b1, "rem_by0");
    issue(3'd4, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, "div_ovf");
    issue(3'd6, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, "rem_ovf");
    wait_idle("corner");
    watch_md_idle = 1'b0;

    // Flush during ISSUE: command held until ready, then no write-back
    issue(3'd4, 5'd9, 32'd100, 32'd7, 6, 1'b0, "div_flush");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (!md_ready && n < 50) begin
      check("drain_md_op", md_op, 2'd2);
      check("drain_md_rs1", md_rs1, 32'd100);
      @(negedge clk);
      n++;
    end
    check("drain_ready_seen", md_ready, 1'b1);
    check("drain_md_op_at_ready", md_op, 2'd2);
    @(negedge clk);
    check("flush_gap_md_op", md_op, 2'd0);
    check("flush_gap_busy", busy, 1'b1);
    @(negedge clk);
    check("flush_back_idle", req_ready, 1'b1);
    issue(3'd0, 5'd11, 32'hFFFF_FFFB, 32'd9, 0, 1'b1, "mul_after_flush");
    wait_idle("flush");

    // Timeout with a unit that never answers
    unit_hang = 1'b1;
    issue(3'd3, 5'd3, 32'h1234, 32'h5678, 0, 1'b0, "hang");
    t0 = cyc - 1;
    check("hang_md_op", md_op, 2'd1);
    n = 0;
    while (!timeout_err && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    d = cyc - t0;
    check("timeout_raised", timeout_err, 1'b1);
    check("timeout_window", (d >= TIMEOUT && d <= TIMEOUT + 3), 1'b1);
    wait_idle("timeout");
    unit_hang = 1'b0;
    issue(3'd0, 5'd4, 32'd12, 32'd12, 1, 1'b1, "mul_after_timeout");
    wait_idle("after_timeout");
    check("timeout_sticky", timeout_err, 1'b1);

    // Reset in the middle of ISSUE
    unit_hang = 1'b1;
    issue(3'd0, 5'd7, 32'd3, 32'd4, 0, 1'b0, "rst_mid");
    @(negedge clk);
    check("rst_pre_busy", busy, 1'b1);
    check("rst_pre_md_op", md_op, 2'd1);
    rst = 1'b1;
    #1;
    check("rst_md_op", md_op, 2'd0);
    check("rst_md_rs1", md_rs1, 32'd0);
    check("rst_md_rs2", md_rs2, 32'd0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    unit_hang = 1'b0;

    // Randomized back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      issue(f3, 5'($urandom_range(1, 31)), pick_operand(), pick_operand(),
            $urandom_range(0, 5), 1'b1, $sformatf("rnd%0d_f%0d", i, f3));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    wait_idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
